// File: rtl/skullfet_pkg.sv
// Shared definitions for the SkullFET cell sequencer: register map,
// control/status bit positions, FSM states and the cell truth tables.
package skullfet_pkg;

  // Register byte offsets from the Wishbone base address
  localparam logic [7:0] OFF_CTRL      = 8'h00;
  localparam logic [7:0] OFF_SETTLE    = 8'h04;
  localparam logic [7:0] OFF_STATUS    = 8'h08;
  localparam logic [7:0] OFF_ERRCNT    = 8'h0C;
  localparam logic [7:0] OFF_LAST_FAIL = 8'h10;
  localparam logic [7:0] OFF_RUNS      = 8'h14;

  // CTRL bit positions
  localparam int CTRL_START = 0;
  localparam int CTRL_LOOP  = 1;
  localparam int CTRL_ABORT = 2;

  // STATUS bit positions
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_PASS = 2;

  // LAST_FAIL bit positions (vector index lives in bits [1:0])
  localparam int LF_INV_BIT  = 2;
  localparam int LF_NAND_BIT = 3;
  localparam int LF_VLD_BIT  = 8;

  // Settle register reset value and the floor that covers the
  // two-flop synchronizer latency
  localparam int SETTLE_RESET = 8;
  localparam int SETTLE_MIN   = 2;

  localparam int RUNS_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } seq_state_t;

  // Expected inverter output for vector idx (inverter input is idx[0])
  function automatic logic exp_inv(input logic [1:0] idx);
    return ~idx[0];
  endfunction

  // Expected NAND output for vector idx (A = idx[1], B = idx[0])
  function automatic logic exp_nand(input logic [1:0] idx);
    return ~(idx[1] & idx[0]);
  endfunction

endpackage

// File: rtl/skullfet_sync2.sv
// Two-flop synchronizer for an asynchronous cell output pad.
module skullfet_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the pad to settle metastability before use
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/skullfet_cell_sequencer.sv
// Wishbone-controlled exerciser for the SkullFET inverter and NAND test
// cells: walks all four input vectors, waits a settle time, samples the
// synchronized outputs and logs errors against the truth tables.
module skullfet_cell_sequencer
  import skullfet_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          ERR_W     = 16,
  parameter int          SETTLE_W  = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        inv_a,
  output logic        nand_a,
  output logic        nand_b,
  input  logic        inv_y,
  input  logic        nand_y,
  output logic        done_irq
);

  seq_state_t state, state_nxt;

  logic [SETTLE_W-1:0] settle_reg;
  logic [SETTLE_W-1:0] eff_settle;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                loop_en;
  logic [1:0]          vec_idx;
  logic [ERR_W-1:0]    errcnt;
  logic [1:0]          lf_idx;
  logic                lf_inv;
  logic                lf_nand;
  logic                lf_vld;
  logic                done_flag;
  logic                pass_flag;
  logic [RUNS_W-1:0]   runs;

  logic        inv_y_s;
  logic        nand_y_s;
  logic        mismatch;

  logic        wb_hit;
  logic        wb_access;
  logic        wb_wr;
  logic        wb_rd;
  logic [7:0]  offset;
  logic [31:0] wmask;
  logic [31:0] settle_merge;
  logic        ctrl_wr;
  logic        settle_wr;
  logic        start_req;
  logic        abort_req;
  logic        start_go;
  logic [31:0] rdata;
  logic        unused_sink;

  skullfet_sync2 u_sync_inv (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   (inv_y),
    .q   (inv_y_s)
  );

  skullfet_sync2 u_sync_nand (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   (nand_y),
    .q   (nand_y_s)
  );

  // Bus decode, byte-lane merge for SETTLE, and command pulses from CTRL.
  // ABORT in the same write suppresses START so the abort always wins.
  always_comb begin
    wb_hit       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    wb_access    = wb_hit & ~wbs_ack_o;
    wb_wr        = wb_access & wbs_we_i;
    wb_rd        = wb_access & ~wbs_we_i;
    offset       = wbs_adr_i[7:0];
    wmask        = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                    {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    settle_merge = (32'(settle_reg) & ~wmask) | (wbs_dat_i & wmask);
    ctrl_wr      = wb_wr & (offset == OFF_CTRL) & wbs_sel_i[0];
    settle_wr    = wb_wr & (offset == OFF_SETTLE);
    start_req    = ctrl_wr & wbs_dat_i[CTRL_START] & ~wbs_dat_i[CTRL_ABORT];
    abort_req    = ctrl_wr & wbs_dat_i[CTRL_ABORT];
    start_go     = start_req & (state == ST_IDLE);
    unused_sink  = ^{wbs_dat_i, settle_merge};
  end

  // Settle floor, compare of synchronized outputs against the truth table
  always_comb begin
    eff_settle = (settle_reg < SETTLE_W'(SETTLE_MIN)) ? SETTLE_W'(SETTLE_MIN) : settle_reg;
    mismatch   = (inv_y_s != exp_inv(vec_idx)) | (nand_y_s != exp_nand(vec_idx));
  end

  // Register-file read mux
  always_comb begin
    rdata = '0;
    case (offset)
      OFF_CTRL:   rdata[CTRL_LOOP] = loop_en;
      OFF_SETTLE: rdata[SETTLE_W-1:0] = settle_reg;
      OFF_STATUS: begin
        rdata[STAT_BUSY] = (state != ST_IDLE);
        rdata[STAT_DONE] = done_flag;
        rdata[STAT_PASS] = pass_flag;
      end
      OFF_ERRCNT: rdata[ERR_W-1:0] = errcnt;
      OFF_LAST_FAIL: begin
        rdata[1:0]         = lf_idx;
        rdata[LF_INV_BIT]  = lf_inv;
        rdata[LF_NAND_BIT] = lf_nand;
        rdata[LF_VLD_BIT]  = lf_vld;
      end
      OFF_RUNS:   rdata[RUNS_W-1:0] = runs;
      default:    rdata = '0;
    endcase
  end

  // Wishbone slave: one-cycle ack pulse, read data registered alongside it
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      loop_en    <= 1'b0;
      settle_reg <= SETTLE_W'(SETTLE_RESET);
    end else begin
      wbs_ack_o <= wb_access;
      wbs_dat_o <= wb_rd ? rdata : 32'h0;
      if (ctrl_wr) begin
        loop_en <= wbs_dat_i[CTRL_LOOP];
      end
      if (settle_wr) begin
        settle_reg <= settle_merge[SETTLE_W-1:0];
      end
    end
  end

  // FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic; ABORT overrides every transition
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start_go) state_nxt = ST_APPLY;
      ST_APPLY:  state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_cnt <= SETTLE_W'(1)) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = (vec_idx == 2'd3) ? ST_DONE : ST_APPLY;
      ST_DONE:   state_nxt = loop_en ? ST_APPLY : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (abort_req) begin
      state_nxt = ST_IDLE;
    end
  end

  // Sequencer datapath: pad drives, settle count, error log, run bookkeeping
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      inv_a      <= 1'b0;
      nand_a     <= 1'b0;
      nand_b     <= 1'b0;
      done_irq   <= 1'b0;
      vec_idx    <= 2'd0;
      settle_cnt <= '0;
      errcnt     <= '0;
      lf_idx     <= 2'd0;
      lf_inv     <= 1'b0;
      lf_nand    <= 1'b0;
      lf_vld     <= 1'b0;
      done_flag  <= 1'b0;
      pass_flag  <= 1'b0;
      runs       <= '0;
    end else begin
      done_irq <= 1'b0;
      if (abort_req) begin
        inv_a  <= 1'b0;
        nand_a <= 1'b0;
        nand_b <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_go) begin
              vec_idx   <= 2'd0;
              errcnt    <= '0;
              lf_idx    <= 2'd0;
              lf_inv    <= 1'b0;
              lf_nand   <= 1'b0;
              lf_vld    <= 1'b0;
              done_flag <= 1'b0;
              pass_flag <= 1'b0;
            end
          end
          ST_APPLY: begin
            nand_a     <= vec_idx[1];
            nand_b     <= vec_idx[0];
            inv_a      <= vec_idx[0];
            settle_cnt <= eff_settle;
          end
          ST_SETTLE: begin
            settle_cnt <= settle_cnt - SETTLE_W'(1);
          end
          ST_SAMPLE: begin
            if (mismatch) begin
              if (errcnt != {ERR_W{1'b1}}) begin
                errcnt <= errcnt + ERR_W'(1);
              end
              if (!lf_vld) begin
                lf_idx  <= vec_idx;
                lf_inv  <= inv_y_s;
                lf_nand <= nand_y_s;
                lf_vld  <= 1'b1;
              end
            end
            vec_idx <= vec_idx + 2'd1;
          end
          ST_DONE: begin
            done_flag <= 1'b1;
            pass_flag <= (errcnt == '0);
            done_irq  <= 1'b1;
            runs      <= runs + RUNS_W'(1);
            if (loop_en) begin
              vec_idx <= 2'd0;
              errcnt  <= '0;
              lf_idx  <= 2'd0;
              lf_inv  <= 1'b0;
              lf_nand <= 1'b0;
              lf_vld  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/skullfet_cell_sequencer.md
Name: skullfet_cell_sequencer

Overview:
Wishbone-controlled exerciser for the SkullFET inverter and NAND test cells on the user IO pads. It walks all input vectors (inverter A; NAND A/B) and waits a programmable settle time. It then samples the cell outputs through a 2-flop synchronizer, compares them against the expected truth table, and logs errors and the first failing vector. It sits inside the user project wrapper between the Caravel Wishbone bus and the cell pad nets.

Parameters:
BASE_ADDR, 32'h3000_0000, Wishbone base address; decode on adr[31:8].
ERR_W, 16, error counter width; counter saturates.
SETTLE_W, 8, settle-count register width.

Ports:
wb_clk_i  in  1  the only clock.
wb_rst_i  in  1  synchronous, active-high reset.
wbs_cyc_i  in  1  Wishbone cycle.
wbs_stb_i  in  1  Wishbone strobe.
wbs_we_i  in  1  write enable.
wbs_sel_i  in  4  byte selects; register writes honour them.
wbs_adr_i  in  32  address.
wbs_dat_i  in  32  write data.
wbs_ack_o  out  1  acknowledge.
wbs_dat_o  out  32  read data.
inv_a  out  1  drives inverter input pad.
nand_a  out  1  drives NAND input A pad.
nand_b  out  1  drives NAND input B pad.
inv_y  in  1  inverter output, asynchronous.
nand_y  in  1  NAND output, asynchronous.
done_irq  out  1  one-cycle pulse at end of a run.

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset is synchronous and active-high on wb_rst_i.
- Reset values: all outputs 0. State IDLE. SETTLE register = 8. Counters, LAST_FAIL and status bits cleared.
- Registers (offset from BASE_ADDR):
  - 0x00 CTRL: bit0 START (write-1 pulse, reads 0); bit1 LOOP (R/W, repeat runs); bit2 ABORT (write-1 pulse).
  - 0x04 SETTLE: [SETTLE_W-1:0], R/W. Effective value = max(SETTLE, 2) to cover synchronizer latency.
  - 0x08 STATUS (RO): bit0 BUSY, bit1 DONE (sticky; cleared by START), bit2 PASS (valid when DONE).
  - 0x0C ERRCNT (RO): cleared by START.
  - 0x10 LAST_FAIL (RO): bits[1:0] = vector index; bit2 = inv_y seen; bit3 = nand_y seen; bit8 = valid. Captures the first failure of a run.
  - 0x14 RUNS (RO, 16b): completed runs, wraps.
  - Unmapped offsets: read 0; writes ignored.
- Wishbone access:
  - ack asserts the cycle after cyc&stb while ack is low. It is a one-cycle pulse, so back-to-back access gives one ack every 2 cycles.
  - Read data is valid with ack.
  - Accesses outside BASE_ADDR[31:8] get no ack.
- FSM states: IDLE -> APPLY -> SETTLE -> SAMPLE -> (NEXT) -> DONE -> IDLE.
  - IDLE: START -> APPLY, with vector idx=0, ERRCNT=0, LAST_FAIL=0, DONE=0.
  - APPLY (1 cycle): nand_a=idx[1], nand_b=idx[0], inv_a=idx[0]. These drive values are registered and held until the next APPLY.
  - SETTLE: count effective settle cycles, then go to SAMPLE.
  - SAMPLE (1 cycle): compare synchronized inputs against expected values (inv_y = ~idx[0]; nand_y = ~(idx[1]&idx[0])).
    - Any mismatch increments ERRCNT (saturating at all-ones).
    - On the first mismatch of the run, LAST_FAIL is captured.
    - idx==3 -> DONE; otherwise idx+1 -> APPLY.
  - DONE (1 cycle): DONE=1, PASS=(ERRCNT==0), done_irq=1, RUNS+1.
    - LOOP=1: go to APPLY, with idx=0 and ERRCNT/LAST_FAIL cleared.
    - Otherwise go to IDLE.
- Run latency: one run = 4*(eff_settle+2)+1 cycles from START to done_irq.
- BUSY = state != IDLE.
- Boundary conditions:
  - START while BUSY: ignored.
  - ABORT: returns to IDLE next cycle from any state; DONE is not set; no done_irq; drive outputs go to 0.
  - START and ABORT written together: ABORT wins.
  - SETTLE written mid-run: takes effect at the next SETTLE entry.
  - Reset mid-run: immediate return to reset values.
  - Clearing LOOP mid-run: the current run finishes, then the FSM goes to IDLE.

Decomposition:
- Shared package skullfet_pkg holds:
  - register offset localparams;
  - state enum;
  - CTRL/STATUS bit positions;
  - expected-value function exp_inv(idx) / exp_nand(idx).
- One natural sub-module: skullfet_sync2, a 2-flop synchronizer with reset to 0, instantiated once per sampled input.

Test Plan:
- Good cells: model inv_y=~inv_a, nand_y=~(nand_a&nand_b); write SETTLE=4, START -> done_irq after 25 cycles; STATUS=0b110; ERRCNT=0; LAST_FAIL=0; RUNS=1.
- Stuck-at-1 NAND: nand_y tied 1; START -> ERRCNT=1; LAST_FAIL=0x10B (idx 3, inv_y=0, nand_y=1, valid); PASS=0.
- SETTLE=0: START -> effective settle 2; done_irq 17 cycles after START; good cells pass.
- Abort and restart: ABORT during SETTLE of idx 2 -> IDLE next cycle, outputs 0, DONE=0, no irq. Then START while BUSY in a fresh run -> ignored; ERRCNT unchanged.
- LOOP mode: LOOP=1, START, inverter output stuck 0 -> each run ERRCNT=2. Clear LOOP after 3 done_irqs -> FSM stops after the current run; RUNS=4.
- Wishbone: read 0x20 -> 0 with ack; address BASE+0x100 -> no ack; write SETTLE with sel=4'b0000 -> value unchanged; reset mid-run -> all registers at reset values.
